// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared definitions for the data-side memory bus interface unit.
//   - SIZE encodings for the bus and the core request
//   - FSM state enum for mem_bus_if
//   - size_bytes():    SIZE encoding -> access width in bytes
//   - is_misaligned(): natural-alignment test on the low address bits
package mem_bus_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDone   = 2'd2,
        StFault  = 2'd3
    } state_e;

    localparam logic [1:0] SizeByte  = 2'b00;
    localparam logic [1:0] SizeHalf  = 2'b01;
    localparam logic [1:0] SizeWord  = 2'b10;
    localparam logic [1:0] SizeDword = 2'b11;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        logic [3:0] n;
        case (size)
            SizeByte: n = 4'd1;
            SizeHalf: n = 4'd2;
            SizeWord: n = 4'd4;
            default:  n = 4'd8;
        endcase
        return n;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] addr_lo);
        logic m;
        case (size)
            SizeHalf:  m = addr_lo[0] != 1'b0;
            SizeWord:  m = addr_lo[1:0] != 2'b00;
            SizeDword: m = addr_lo[2:0] != 3'b000;
            default:   m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_bus_if_if.sv
// mem_bus_if_if: signal bundle between the core, mem_bus_if and the data bus pins.
//   Core side : i_req, i_write, i_size, i_signed, i_addr, i_wdata -> unit
//               o_rdata, o_done, o_fault, o_stall                -> core
//   Pin side  : o_dad, o_mreq, o_write, o_size, o_ddt, o_ddt_oe  -> pins
//               i_ddt, i_ackd_n (active-low acknowledge)         -> unit
//   Modports  : slave  = the mem_bus_if unit
//               master = whatever drives the core and bus sides (core + pins / testbench)
interface mem_bus_if_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32
);

    logic              i_req;
    logic              i_write;
    logic [1:0]        i_size;
    logic              i_signed;
    logic [ADDR_W-1:0] i_addr;
    logic [XLEN-1:0]   i_wdata;
    logic [XLEN-1:0]   o_rdata;
    logic              o_done;
    logic              o_fault;
    logic              o_stall;
    logic [ADDR_W-1:0] o_dad;
    logic              o_mreq;
    logic              o_write;
    logic [1:0]        o_size;
    logic [XLEN-1:0]   o_ddt;
    logic              o_ddt_oe;
    logic [XLEN-1:0]   i_ddt;
    logic              i_ackd_n;

    modport slave (
        input  i_req, i_write, i_size, i_signed, i_addr, i_wdata, i_ddt, i_ackd_n,
        output o_rdata, o_done, o_fault, o_stall, o_dad, o_mreq, o_write, o_size,
               o_ddt, o_ddt_oe
    );

    modport master (
        output i_req, i_write, i_size, i_signed, i_addr, i_wdata, i_ddt, i_ackd_n,
        input  o_rdata, o_done, o_fault, o_stall, o_dad, o_mreq, o_write, o_size,
               o_ddt, o_ddt_oe
    );

endinterface

// File: rtl/mem_bus_if_lane_align.sv
// mem_bus_if_lane_align: combinational byte-lane steering for mem_bus_if.
//   Store path: st_data (right-aligned) replicated across all lanes at st_size granularity,
//               so the byte at address offset n always lands on lanes[8n+7:8n].
//   Load path : ld_lanes shifted down by ld_offset bytes, then zero- or sign-extended
//               from bit 8*bytes(ld_size)-1.
// Ports
//   st_size, st_data -> st_lanes
//   ld_size, ld_signed, ld_offset, ld_lanes -> ld_data
module mem_bus_if_lane_align
    import mem_bus_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [1:0]                st_size,
    input  logic [XLEN-1:0]           st_data,
    output logic [XLEN-1:0]           st_lanes,
    input  logic [1:0]                ld_size,
    input  logic                      ld_signed,
    input  logic [$clog2(XLEN/8)-1:0] ld_offset,
    input  logic [XLEN-1:0]           ld_lanes,
    output logic [XLEN-1:0]           ld_data
);

    localparam int unsigned IdxW = $clog2(XLEN);

    logic [XLEN-1:0] shifted;
    int unsigned     nbits;
    logic [IdxW-1:0] sign_idx;
    logic            ext;

    always_comb begin
        st_lanes = st_data;
        case (st_size)
            SizeByte: st_lanes = {(XLEN / 8){st_data[7:0]}};
            SizeHalf: st_lanes = {(XLEN / 16){st_data[15:0]}};
            SizeWord: st_lanes = {(XLEN / 32){st_data[31:0]}};
            default:  st_lanes = st_data;
        endcase
    end

    always_comb begin
        ld_data  = '0;
        shifted  = ld_lanes >> {ld_offset, 3'b000};
        nbits    = 8 * 32'(size_bytes(ld_size));
        // Unsupported widths never reach DONE; clamp keeps the index in range.
        if (nbits > XLEN) begin
            nbits = XLEN;
        end
        sign_idx = IdxW'(nbits - 1);
        ext      = ld_signed & shifted[sign_idx];
        for (int i = 0; i < XLEN; i++) begin
            ld_data[i] = (32'(i) < nbits) ? shifted[i] : ext;
        end
    end

endmodule

// File: rtl/mem_bus_if.sv
// mem_bus_if: data-side memory bus interface unit.
//   Latches a core load/store request, runs the DAD/MREQ/WRITE/SIZE + ACKD_n wait-state
//   handshake, stalls the core until completion, lane-aligns store data, right-aligns and
//   extends load data, and aborts an access whose acknowledge never arrives (TIMEOUT cycles).
// Ports
//   i_clk      clock
//   i_reset_x  asynchronous active-low reset
//   bus        mem_bus_if_if.slave: core request/response and bus pin signals
// Build option
//   MEM_BUS_MISALIGN_SPLIT_EN: when defined, a misaligned access is carried out as a run of
//   single-byte beats (each a full ACK handshake with its own watchdog). When undefined a
//   misaligned request faults on the next cycle without touching the bus.
// Requests whose size exceeds XLEN (dword on a 32-bit build) fault the same way.
module mem_bus_if
    import mem_bus_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_reset_x,
    mem_bus_if_if.slave bus
);

    localparam int unsigned OffW     = $clog2(XLEN / 8);
    localparam int unsigned MaxBytes = XLEN / 8;
    localparam int unsigned WaitW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              write_q;
    logic              signed_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   ddt_q;
    logic [WaitW-1:0]  wait_q;

    logic              ack;
    logic              size_ok;
    logic              req_misaligned;
    logic              last_beat;
    logic              in_access;
    logic              done;
    logic [ADDR_W-1:0] cur_addr;
    logic [1:0]        cur_size;
    logic [XLEN-1:0]   st_src;
    logic [XLEN-1:0]   st_lanes;
    logic [XLEN-1:0]   ld_src;
    logic [XLEN-1:0]   ld_data;
    logic [OffW-1:0]   ld_off;

    assign ack            = ~bus.i_ackd_n;
    assign size_ok        = 32'(size_bytes(bus.i_size)) <= MaxBytes;
    assign req_misaligned = is_misaligned(bus.i_size, bus.i_addr[2:0]);

`ifdef MEM_BUS_MISALIGN_SPLIT_EN
    logic            split_q;
    logic [2:0]      beat_q;
    logic [XLEN-1:0] asm_q;
    logic [7:0]      beat_byte;

    assign last_beat = ~split_q | (beat_q == 3'(size_bytes(size_q) - 4'd1));
    assign cur_addr  = addr_q + ADDR_W'(beat_q);
    assign cur_size  = split_q ? SizeByte : size_q;
    // Beat k carries store byte k; loads are assembled little-endian into asm_q.
    assign st_src    = wdata_q >> {beat_q, 3'b000};
    assign ld_src    = split_q ? asm_q : ddt_q;
    assign ld_off    = split_q ? '0 : addr_q[OffW-1:0];
    assign beat_byte = 8'(bus.i_ddt >> {cur_addr[OffW-1:0], 3'b000});

    always_ff @(posedge i_clk or negedge i_reset_x) begin
        if (!i_reset_x) begin
            split_q <= 1'b0;
            beat_q  <= '0;
            asm_q   <= '0;
        end else if (state_q == StIdle && bus.i_req) begin
            split_q <= req_misaligned;
            beat_q  <= '0;
        end else if (state_q == StAccess && ack && split_q) begin
            asm_q[{beat_q, 3'b000} +: 8] <= beat_byte;
            beat_q                       <= beat_q + 3'd1;
        end
    end
`else
    assign last_beat = 1'b1;
    assign cur_addr  = addr_q;
    assign cur_size  = size_q;
    assign st_src    = wdata_q;
    assign ld_src    = ddt_q;
    assign ld_off    = addr_q[OffW-1:0];
`endif

    always_ff @(posedge i_clk or negedge i_reset_x) begin
        if (!i_reset_x) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.i_req) begin
                    if (!size_ok) begin
                        state_d = StFault;
`ifdef MEM_BUS_MISALIGN_SPLIT_EN
                    end else begin
                        state_d = StAccess;
`else
                    end else if (req_misaligned) begin
                        state_d = StFault;
                    end else begin
                        state_d = StAccess;
`endif
                    end
                end
            end
            StAccess: begin
                // An ack on the last watchdog cycle still completes the beat.
                if (ack) begin
                    state_d = last_beat ? StDone : StAccess;
                end else if (wait_q == WaitLast) begin
                    state_d = StFault;
                end
            end
            StDone:  state_d = StIdle;
            StFault: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_x) begin
        if (!i_reset_x) begin
            addr_q   <= '0;
            size_q   <= 2'b00;
            write_q  <= 1'b0;
            signed_q <= 1'b0;
            wdata_q  <= '0;
            ddt_q    <= '0;
            wait_q   <= '0;
        end else begin
            if (state_q == StIdle && bus.i_req) begin
                addr_q   <= bus.i_addr;
                size_q   <= bus.i_size;
                write_q  <= bus.i_write;
                signed_q <= bus.i_signed;
                wdata_q  <= bus.i_wdata;
                wait_q   <= '0;
            end
            if (state_q == StAccess) begin
                if (ack) begin
                    ddt_q  <= bus.i_ddt;
                    wait_q <= '0;
                end else begin
                    wait_q <= wait_q + WaitW'(1);
                end
            end
        end
    end

    mem_bus_if_lane_align #(
        .XLEN(XLEN)
    ) u_lane_align (
        .st_size  (cur_size),
        .st_data  (st_src),
        .st_lanes (st_lanes),
        .ld_size  (size_q),
        .ld_signed(signed_q),
        .ld_offset(ld_off),
        .ld_lanes (ld_src),
        .ld_data  (ld_data)
    );

    assign in_access    = state_q == StAccess;
    assign done         = (state_q == StDone) || (state_q == StFault);

    // Pin-side outputs are forced to zero outside ACCESS so the bus is quiet when idle.
    assign bus.o_mreq   = in_access;
    assign bus.o_dad    = in_access ? cur_addr : '0;
    assign bus.o_write  = in_access & write_q;
    assign bus.o_size   = in_access ? cur_size : 2'b00;
    assign bus.o_ddt_oe = in_access & write_q;
    assign bus.o_ddt    = (in_access & write_q) ? st_lanes : '0;

    assign bus.o_done   = done;
    assign bus.o_fault  = state_q == StFault;
    assign bus.o_rdata  = (state_q == StDone && !write_q) ? ld_data : '0;
    assign bus.o_stall  = bus.i_req & ~done;

endmodule

// File: tb/tb_mem_bus_if.sv
// tb_mem_bus_if: self-checking bench for mem_bus_if (XLEN=32, TIMEOUT=8).
// A byte-array bus slave answers accesses after a chosen number of wait states; a separate
// reference memory plus arithmetic expectations predict latency, fault, load value and
// the final memory image. Honors MEM_BUS_MISALIGN_SPLIT_EN when defined.
module tb_mem_bus_if;
    import mem_bus_pkg::*;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned TIMEOUT = 8;
    localparam int          MemSize = 512;
    localparam int          NoAck   = 99;
`ifdef MEM_BUS_MISALIGN_SPLIT_EN
    localparam bit SplitEn = 1'b1;
`else
    localparam bit SplitEn = 1'b0;
`endif

    logic clk     = 1'b0;
    logic reset_x = 1'b0;
    always #5 clk = ~clk;

    mem_bus_if_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

    mem_bus_if #(
        .XLEN   (XLEN),
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk    (clk),
        .i_reset_x(reset_x),
        .bus      (bus.slave)
    );

    logic [7:0] bus_mem [MemSize];
    logic [7:0] ref_mem [MemSize];
    int n_checks = 0;
    int n_pass   = 0;
    int bwait    = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Bus slave: acks the w-th cycle of each beat; idle acks are random noise.
    task automatic slave_step(input int w);
        int base;
        int off;
        int nb;
        if (bus.o_mreq) begin
            if (bwait >= w) begin
                bus.i_ackd_n = 1'b0;
                base = int'(bus.o_dad) & ~3;
                for (int n = 0; n < 4; n++) bus.i_ddt[8*n +: 8] = bus_mem[(base + n) % MemSize];
                if (bus.o_write) begin
                    off = int'(bus.o_dad[1:0]);
                    nb  = 1 << bus.o_size;
                    for (int n = off; n < off + nb && n < 4; n++)
                        bus_mem[(base + n) % MemSize] = bus.o_ddt[8*n +: 8];
                end
                bwait = 0;
            end else begin
                bus.i_ackd_n = 1'b1;
                bwait++;
            end
        end else begin
            bus.i_ackd_n = 1'($urandom_range(0, 1));
            bus.i_ddt    = $urandom;
            bwait        = 0;
        end
    endtask

    task automatic do_txn(input logic wr, input logic [1:0] sz, input logic sg, input int addr,
                          input logic [31:0] wd, input int w, input logic keep, input string name);
        int          nbytes;
        int          beats;
        int          exp_done;
        int          diffs;
        bit          misal;
        bit          to_bus;
        bit          faulty;
        bit          exp_mreq;
        bit          ok;
        logic [63:0] v;
        logic [31:0] exp_rd;

        nbytes = 1 << sz;
        misal  = (addr % nbytes) != 0;
        beats  = misal ? nbytes : 1;
        if (nbytes > 4 || (misal && !SplitEn)) begin
            to_bus = 0; faulty = 1; exp_done = 1;
        end else if (w >= int'(TIMEOUT)) begin
            to_bus = 1; faulty = 1; exp_done = 1 + TIMEOUT;
        end else begin
            to_bus = 1; faulty = 0; exp_done = 1 + beats * (w + 1);
        end
        exp_rd = '0;
        if (!faulty && !wr) begin
            v = '0;
            for (int i = 0; i < nbytes; i++) v |= 64'(ref_mem[addr + i]) << (8 * i);
            if (sg && v[8*nbytes-1]) v |= ~((64'd1 << (8 * nbytes)) - 1);
            exp_rd = v[31:0];
        end
        if (!faulty && wr)
            for (int i = 0; i < nbytes; i++) ref_mem[addr + i] = wd[8*i +: 8];

        @(posedge clk); #1;
        bus.i_req    = 1'b1;
        bus.i_write  = wr;
        bus.i_size   = sz;
        bus.i_signed = sg;
        bus.i_addr   = addr;
        bus.i_wdata  = wd;
        bwait        = 0;
        for (int c = 0; c <= exp_done; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            slave_step(w);
            @(negedge clk);
            exp_mreq = to_bus && c >= 1 && c < exp_done;
            check_eq($sformatf("%s.mreq.c%0d", name, c), 64'(bus.o_mreq), 64'(exp_mreq));
            check_eq($sformatf("%s.stall.c%0d", name, c), 64'(bus.o_stall), 64'(c != exp_done));
            check_eq($sformatf("%s.done.c%0d", name, c), 64'(bus.o_done), 64'(c == exp_done));
            if (exp_mreq) begin
                check_eq($sformatf("%s.dad.c%0d", name, c), 64'(bus.o_dad),
                         64'(addr + (misal ? (c - 1) / (w + 1) : 0)));
                check_eq($sformatf("%s.size.c%0d", name, c), 64'(bus.o_size),
                         64'(misal ? 2'b00 : sz));
                check_eq($sformatf("%s.oe.c%0d", name, c), 64'(bus.o_ddt_oe), 64'(wr));
            end
            if (c == exp_done) begin
                check_eq($sformatf("%s.fault", name), 64'(bus.o_fault), 64'(faulty));
                check_eq($sformatf("%s.rdata", name), 64'(bus.o_rdata), 64'(exp_rd));
            end
        end
        if (!keep) begin
            bus.i_req    = 1'b0;
            bus.i_ackd_n = 1'b1;
            ok = 0;
            for (int k = 0; k < 20; k++) begin
                @(posedge clk); #1;
                if (!bus.o_mreq && !bus.o_done) begin ok = 1; break; end
            end
            check_eq($sformatf("%s.drain", name), 64'(ok), 64'd1);
        end
        diffs = 0;
        for (int i = 0; i < MemSize; i++) if (bus_mem[i] !== ref_mem[i]) diffs++;
        check_eq($sformatf("%s.mem", name), 64'(diffs), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_req    = 1'b0;
        bus.i_write  = 1'b0;
        bus.i_size   = 2'b00;
        bus.i_signed = 1'b0;
        bus.i_addr   = '0;
        bus.i_wdata  = '0;
        bus.i_ddt    = '0;
        bus.i_ackd_n = 1'b1;
        for (int i = 0; i < MemSize; i++) begin
            bus_mem[i] = 8'($urandom);
            ref_mem[i] = bus_mem[i];
        end
        {bus_mem['h103], bus_mem['h102], bus_mem['h101], bus_mem['h100]} = 32'hDEADBEEF;
        for (int i = 'h100; i < 'h104; i++) ref_mem[i] = bus_mem[i];

        // Outputs while reset is held.
        #12;
        check_eq("rst.mreq", 64'(bus.o_mreq), 64'd0);
        check_eq("rst.done", 64'(bus.o_done), 64'd0);
        check_eq("rst.fault", 64'(bus.o_fault), 64'd0);
        check_eq("rst.stall", 64'(bus.o_stall), 64'd0);
        check_eq("rst.rdata", 64'(bus.o_rdata), 64'd0);
        check_eq("rst.dad", 64'(bus.o_dad), 64'd0);
        check_eq("rst.oe", 64'(bus.o_ddt_oe), 64'd0);
        @(negedge clk);
        reset_x = 1'b1;

        do_txn(1'b0, SizeWord, 1'b0, 'h100, 32'h0, 2, 1'b0, "t1_word_load");
        bus_mem['h103] = 8'h80;
        ref_mem['h103] = 8'h80;
        do_txn(1'b0, SizeByte, 1'b1, 'h103, 32'h0, 0, 1'b0, "t2_byte_signed");
        do_txn(1'b0, SizeByte, 1'b0, 'h103, 32'h0, 1, 1'b0, "t2_byte_unsigned");
        do_txn(1'b1, SizeHalf, 1'b0, 'h102, 32'h1234ABCD, 1, 1'b0, "t3_half_store");
        do_txn(1'b0, SizeWord, 1'b0, 'h100, 32'h0, NoAck, 1'b0, "t4_timeout");
        do_txn(1'b0, SizeWord, 1'b0, 'h101, 32'h0, 1, 1'b0, "t5_misaligned");
        do_txn(1'b0, SizeDword, 1'b0, 'h100, 32'h0, 0, 1'b0, "dword_on_32");
        do_txn(1'b1, SizeWord, 1'b0, 'h20, 32'hCAFEF00D, 0, 1'b1, "b2b_a");
        do_txn(1'b0, SizeWord, 1'b1, 'h20, 32'h0, 1, 1'b0, "b2b_b");

        // Reset in the middle of a wait.
        @(posedge clk); #1;
        bus.i_req    = 1'b1;
        bus.i_write  = 1'b0;
        bus.i_size   = SizeWord;
        bus.i_addr   = 'h40;
        bus.i_ackd_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check_eq("t6.pre_mreq", 64'(bus.o_mreq), 64'd1);
        reset_x = 1'b0;
        #1;
        check_eq("t6.mreq", 64'(bus.o_mreq), 64'd0);
        check_eq("t6.done", 64'(bus.o_done), 64'd0);
        bus.i_req = 1'b0;
        @(posedge clk); #1;
        check_eq("t6.mreq_held", 64'(bus.o_mreq), 64'd0);
        @(negedge clk);
        reset_x = 1'b1;
        do_txn(1'b0, SizeWord, 1'b0, 'h100, 32'h0, 1, 1'b0, "t6_after_reset");

        for (int i = 0; i < 80; i++) begin
            int          a;
            int          w;
            logic [1:0]  sz;
            logic        keep;
            a    = $urandom_range(0, 255);
            sz   = 2'($urandom_range(0, 3));
            w    = ($urandom_range(0, 7) == 0) ? NoAck : $urandom_range(0, 3);
            keep = (i != 79) && ($urandom_range(0, 3) == 0);
            do_txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, w,
                   keep, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
